// File: rtl/eq2_bist_pkg.sv
// Shared definitions for the eq2 built-in self-test engine.
//   - state_e      : BIST controller states
//   - NUM_VEC      : number of (a, b) vectors applied per run
//   - IDX_W, ERR_W : vector index and error counter widths
//   - vec_expected : golden equality result for a vector index
package eq2_bist_pkg;

    localparam int unsigned NUM_VEC = 16;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned ERR_W   = 5;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StCheck  = 2'd2,
        StDone   = 2'd3
    } state_e;

    // Index packs operand a in [3:2] and operand b in [1:0].
    function automatic logic vec_expected(logic [IDX_W-1:0] idx);
        return idx[3:2] == idx[1:0];
    endfunction

endpackage

// File: rtl/eq2_bist_vec_counter.sv
// Vector index counter for the eq2 BIST engine.
// Mod-2^Width up-counter with synchronous clear and enable.
//   clk_i   : clock, rising edge
//   reset_i : synchronous active-high reset
//   clr_i   : synchronous clear (wins over enable)
//   en_i    : count enable
//   cnt_o   : current count
//   tc_o    : terminal count (count is all ones)
module vec_counter #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [Width-1:0] cnt_o,
    output logic             tc_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == '1);

endmodule

// File: rtl/eq2_bist.sv
// Built-in self-test engine for the 2-bit equality comparator eq2.
// On start, applies all 16 (a, b) pairs, holds each for SETTLE+1 clocks,
// samples aeqb in the last of those clocks and accumulates results.
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset
//   start      : run request, accepted only when not busy
//   dut_aeqb   : comparator output under test
//   dut_a      : comparator operand a (vector index [3:2])
//   dut_b      : comparator operand b (vector index [1:0])
//   busy       : test running
//   done       : test finished, results valid
//   pass       : no mismatches (valid while done)
//   err_count  : number of mismatching vectors
//   first_fail : index of the first mismatching vector, 0 if none
module eq2_bist
    import eq2_bist_pkg::*;
#(
    parameter int unsigned SETTLE = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dut_aeqb,
    output logic [1:0]       dut_a,
    output logic [1:0]       dut_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [IDX_W-1:0] first_fail
);

    state_e           state_q, state_d;
    logic [3:0]       wait_cnt_q, wait_cnt_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic [IDX_W-1:0] first_fail_q, first_fail_d;
    logic             fail_seen_q, fail_seen_d;

    logic [IDX_W-1:0] vec_idx;
    logic             vec_last;
    logic             cnt_clr;
    logic             cnt_en;

    vec_counter #(
        .Width (IDX_W)
    ) u_vec_counter (
        .clk_i   (clk),
        .reset_i (reset),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .cnt_o   (vec_idx),
        .tc_o    (vec_last)
    );

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        err_count_d  = err_count_q;
        first_fail_d = first_fail_q;
        fail_seen_d  = fail_seen_q;
        cnt_clr      = 1'b0;
        cnt_en       = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d      = StSettle;
                    wait_cnt_d   = '0;
                    err_count_d  = '0;
                    first_fail_d = '0;
                    fail_seen_d  = 1'b0;
                    cnt_clr      = 1'b1;
                end
            end
            StSettle: begin
                wait_cnt_d = wait_cnt_q + 4'd1;
                if (wait_cnt_q == 4'(SETTLE - 1)) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (dut_aeqb != vec_expected(vec_idx)) begin
                    err_count_d = err_count_q + ERR_W'(1);
                    if (!fail_seen_q) begin
                        first_fail_d = vec_idx;
                        fail_seen_d  = 1'b1;
                    end
                end
                // Counter is not advanced past the last vector so the final
                // operands stay applied while results are held.
                if (vec_last) begin
                    state_d = StDone;
                end else begin
                    cnt_en     = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = StSettle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            wait_cnt_q   <= '0;
            err_count_q  <= '0;
            first_fail_q <= '0;
            fail_seen_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            err_count_q  <= err_count_d;
            first_fail_q <= first_fail_d;
            fail_seen_q  <= fail_seen_d;
        end
    end

    assign dut_a      = vec_idx[3:2];
    assign dut_b      = vec_idx[1:0];
    assign busy       = (state_q == StSettle) || (state_q == StCheck);
    assign done       = (state_q == StDone);
    assign pass       = done && (err_count_q == '0);
    assign err_count  = err_count_q;
    assign first_fail = first_fail_q;

endmodule

// File: tb/tb_eq2_bist.sv
// Self-checking bench for eq2_bist: models of good and faulty comparators
// feed the engine, and expected results are derived by walking all 16
// vectors in the bench.
module tb_eq2_bist;

    logic       clk = 1'b0;
    logic       reset;
    int         checks = 0;
    int         errors = 0;

    // Comparator behaviour: 0 good, 1 stuck-0, 2 stuck-1, 3 inverted, 4 mask faults
    int          mode = 0;
    logic [15:0] fault_mask = '0;

    // Instance with SETTLE=2 and a combinational comparator model
    logic       start0, aeqb0, busy0, done0, pass0;
    logic [1:0] a0, b0;
    logic [4:0] err0;
    logic [3:0] ff0;

    // Instance with SETTLE=1 and a one-register-latency comparator
    logic       start1, aeqb1, busy1, done1, pass1;
    logic [1:0] a1, b1;
    logic [4:0] err1;
    logic [3:0] ff1;

    always #5 clk = ~clk;

    eq2_bist #(.SETTLE(2)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start0),
        .dut_aeqb   (aeqb0),
        .dut_a      (a0),
        .dut_b      (b0),
        .busy       (busy0),
        .done       (done0),
        .pass       (pass0),
        .err_count  (err0),
        .first_fail (ff0)
    );

    eq2_bist #(.SETTLE(1)) u_dut_s1 (
        .clk        (clk),
        .reset      (reset),
        .start      (start1),
        .dut_aeqb   (aeqb1),
        .dut_a      (a1),
        .dut_b      (b1),
        .busy       (busy1),
        .done       (done1),
        .pass       (pass1),
        .err_count  (err1),
        .first_fail (ff1)
    );

    function automatic logic cmp_out(int m, int v, logic [15:0] mask);
        logic good;
        good = ((v >> 2) == (v & 3));
        case (m)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return ~good;
            4:       return good ^ mask[v];
            default: return good;
        endcase
    endfunction

    always_comb aeqb0 = cmp_out(mode, int'({a0, b0}), fault_mask);

    always @(posedge clk) aeqb1 <= (a1 == b1);

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy0, done0, pass0, err0, ff0, a0, b0} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b pass=%b err=%0d ff=%0d a=%0d b=%0d, required all 0",
                     busy0, done0, pass0, err0, ff0, a0, b0);
        end
        checks++;
        if ({busy1, done1, pass1, err1, ff1, a1, b1} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs_s1: busy=%b done=%b err=%0d, required all 0",
                     busy1, done1, err1);
        end
        reset = 1'b0;
    endtask

    // Full run on the SETTLE=2 instance; extra_start >= 1 pulses start at that edge.
    task automatic run_full(string name, int m, logic [15:0] mask, int extra_start);
        int  exp_err;
        int  exp_ff;
        bit  seen;
        bit  ok;
        int  bad_e;
        mode = m;
        fault_mask = mask;
        exp_err = 0;
        exp_ff = 0;
        seen = 0;
        for (int v = 0; v < 16; v++) begin
            if (cmp_out(m, v, mask) != ((v >> 2) == (v & 3))) begin
                exp_err++;
                if (!seen) begin
                    exp_ff = v;
                    seen = 1;
                end
            end
        end

        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        checks++;
        if (busy0 !== 1'b1 || done0 !== 1'b0 || pass0 !== 1'b0 || err0 !== 5'd0 || ff0 !== 4'd0) begin
            errors++;
            $display("FAIL %s start_edge: busy=%b done=%b pass=%b err=%0d ff=%0d, required 1 0 0 0 0",
                     name, busy0, done0, pass0, err0, ff0);
        end

        ok = 1;
        bad_e = 0;
        for (int e = 1; e < 48; e++) begin
            if (e == extra_start) start0 = 1'b1;
            @(posedge clk);
            #1;
            start0 = 1'b0;
            if (ok && (busy0 !== 1'b1 || done0 !== 1'b0 || int'({a0, b0}) != e / 3)) begin
                ok = 0;
                bad_e = e;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s busy_window: at edge %0d busy=%b done=%b vec=%0d, required 1 0 %0d",
                     name, bad_e, busy0, done0, {a0, b0}, bad_e / 3);
        end

        @(posedge clk);
        #1;
        checks++;
        if (done0 !== 1'b1 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL %s done_edge48: done=%b busy=%b, required 1 0", name, done0, busy0);
        end
        checks++;
        if (err0 !== 5'(exp_err) || ff0 !== 4'(exp_ff) || pass0 !== (exp_err == 0)) begin
            errors++;
            $display("FAIL %s results: err=%0d ff=%0d pass=%b, required %0d %0d %b",
                     name, err0, ff0, pass0, exp_err, exp_ff, exp_err == 0);
        end

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done0 !== 1'b1 || busy0 !== 1'b0 || err0 !== 5'(exp_err) || ff0 !== 4'(exp_ff)) begin
            errors++;
            $display("FAIL %s hold: done=%b busy=%b err=%0d ff=%0d, required 1 0 %0d %0d",
                     name, done0, busy0, err0, ff0, exp_err, exp_ff);
        end
    endtask

    task automatic test_reset_mid_run;
        mode = 1;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        checks++;
        if (int'({a0, b0}) != 5 || busy0 !== 1'b1 || err0 === 5'd0) begin
            errors++;
            $display("FAIL midrun_state: vec=%0d busy=%b err=%0d, required vec 5 busy 1 err nonzero",
                     {a0, b0}, busy0, err0);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if ({busy0, done0, pass0, err0, ff0, a0, b0} !== 17'd0) begin
            errors++;
            $display("FAIL midrun_reset: busy=%b done=%b pass=%b err=%0d ff=%0d vec=%0d, required all 0",
                     busy0, done0, pass0, err0, ff0, {a0, b0});
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: busy=%b done=%b, required 0 0", busy0, done0);
        end
    endtask

    task automatic test_settle1_latency;
        bit ok;
        int bad_e;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        ok = 1;
        bad_e = 0;
        for (int e = 1; e < 32; e++) begin
            @(posedge clk);
            #1;
            if (ok && (busy1 !== 1'b1 || done1 !== 1'b0 || int'({a1, b1}) != e / 2)) begin
                ok = 0;
                bad_e = e;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL s1_busy_window: at edge %0d busy=%b done=%b vec=%0d, required 1 0 %0d",
                     bad_e, busy1, done1, {a1, b1}, bad_e / 2);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done1 !== 1'b1 || busy1 !== 1'b0 || pass1 !== 1'b1 || err1 !== 5'd0) begin
            errors++;
            $display("FAIL s1_done_edge32: done=%b busy=%b pass=%b err=%0d, required 1 0 1 0",
                     done1, busy1, pass1, err1);
        end
    endtask

    initial begin
        logic [15:0] m;
        start0 = 1'b0;
        start1 = 1'b0;
        reset  = 1'b1;

        test_reset();
        run_full("good", 0, 16'h0000, -1);
        run_full("stuck0", 1, 16'h0000, -1);
        run_full("stuck1", 2, 16'h0000, -1);
        run_full("inverted", 3, 16'h0000, -1);
        test_reset_mid_run();
        // Start mid-run must be ignored; the next run's start-edge check then
        // covers clearing of the stuck-1 results from DONE.
        run_full("stuck1_ignored_start", 2, 16'h0000, 20);
        run_full("restart_good", 0, 16'h0000, -1);
        for (int i = 0; i < 4; i++) begin
            m = 16'($urandom);
            run_full("random_mask", 4, m, -1);
        end
        test_settle1_latency();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
